// File: rtl/fnd_scan_ctrl.sv
// Scan sequencer for a 4-digit common-anode FND: per-digit dwell, blanking gap,
// frame-coherent input snapshot, leading-zero suppression and decimal points.
module fnd_scan_ctrl #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  input  logic [15:0] i_digits,
  input  logic [3:0]  i_dp,
  input  logic        i_lz_supp,
  output logic [3:0]  o_fnd_com,
  output logic [7:0]  o_fnd_font,
  output logic [1:0]  o_digit_sel,
  output logic        o_frame_tick
);

  localparam int MAX_CNT = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam bit HAS_GAP = (BLANK_CYCLES > 0);

  localparam logic [CW-1:0] DRIVE_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(HAS_GAP ? BLANK_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_GAP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    sel_n;
  logic          frame_start;

  logic [15:0]   snap_digits, snap_digits_n;
  logic [3:0]    snap_dp, snap_dp_n;
  logic          snap_lz, snap_lz_n;

  logic [3:0]    com_n;
  logic [7:0]    font_n;
  logic [3:0]    code_n;

  // Active-low segment pattern {g,f,e,d,c,b,a} for a hex digit.
  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [7:0] g;
    case (code)
      4'h0:    g = 8'hC0;
      4'h1:    g = 8'hF9;
      4'h2:    g = 8'hA4;
      4'h3:    g = 8'hB0;
      4'h4:    g = 8'h99;
      4'h5:    g = 8'h92;
      4'h6:    g = 8'h82;
      4'h7:    g = 8'hF8;
      4'h8:    g = 8'h80;
      4'h9:    g = 8'h90;
      4'hA:    g = 8'h88;
      4'hB:    g = 8'h83;
      4'hC:    g = 8'hC6;
      4'hD:    g = 8'hA1;
      4'hE:    g = 8'h86;
      default: g = 8'h8E;
    endcase
    return g[6:0];
  endfunction

  // A digit is a leading zero when it and every digit to its left are zero.
  function automatic logic lz_blank(input logic [15:0] d, input logic [1:0] s);
    logic b;
    case (s)
      2'd3:    b = (d[15:12] == 4'h0);
      2'd2:    b = (d[15:8]  == 8'h00);
      2'd1:    b = (d[15:4]  == 12'h000);
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    sel_n       = o_digit_sel;
    frame_start = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_en) begin
          state_n     = ST_DRIVE;
          sel_n       = 2'd0;
          cnt_n       = '0;
          frame_start = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (cnt == DRIVE_LAST) begin
          cnt_n = '0;
          if (HAS_GAP) begin
            state_n = ST_GAP;
          end else begin
            state_n     = ST_DRIVE;
            sel_n       = o_digit_sel + 2'd1;
            frame_start = (o_digit_sel == 2'd3);
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          state_n     = ST_DRIVE;
          cnt_n       = '0;
          sel_n       = o_digit_sel + 2'd1;
          frame_start = (o_digit_sel == 2'd3);
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
        sel_n   = 2'd0;
      end
    endcase

    // Disable overrides everything so a re-enable always begins a fresh frame.
    if (!i_en) begin
      state_n     = ST_IDLE;
      cnt_n       = '0;
      sel_n       = 2'd0;
      frame_start = 1'b0;
    end
  end

  always_comb begin
    snap_digits_n = snap_digits;
    snap_dp_n     = snap_dp;
    snap_lz_n     = snap_lz;
    if (frame_start) begin
      snap_digits_n = i_digits;
      snap_dp_n     = i_dp;
      snap_lz_n     = i_lz_supp;
    end
  end

  // Outputs are built from next-cycle values so they line up with the state register.
  always_comb begin
    com_n  = 4'hF;
    font_n = 8'hFF;
    code_n = snap_digits_n[{sel_n, 2'b00} +: 4];
    if (state_n == ST_DRIVE) begin
      com_n     = ~(4'b0001 << sel_n);
      font_n[7] = ~snap_dp_n[sel_n];
      if (snap_lz_n && lz_blank(snap_digits_n, sel_n)) begin
        font_n[6:0] = 7'h7F;
      end else begin
        font_n[6:0] = glyph(code_n);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      snap_digits  <= 16'h0000;
      snap_dp      <= 4'h0;
      snap_lz      <= 1'b0;
      o_fnd_com    <= 4'hF;
      o_fnd_font   <= 8'hFF;
      o_digit_sel  <= 2'd0;
      o_frame_tick <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      snap_digits  <= snap_digits_n;
      snap_dp      <= snap_dp_n;
      snap_lz      <= snap_lz_n;
      o_fnd_com    <= com_n;
      o_fnd_font   <= font_n;
      o_digit_sel  <= sel_n;
      o_frame_tick <= frame_start;
    end
  end

endmodule
